// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x-oversampling UART receiver; even parity check enabled by `define UART_RX_PARITY_EN
module uart_receiver #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             s_tick,
    input  logic             rx,
    output logic [DBITS-1:0] dout,
    output logic             rx_done_tick,
    output logic             frame_err,
    output logic             parity_err
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_next;
    logic [SW-1:0]    s, s_next;
    logic [2:0]       n, n_next;
    logic [DBITS-1:0] b, b_next;
    logic [DBITS-1:0] dout_next;
    logic             fe_next, done_next;
    logic             rx_meta, rx_s, rx_prev;

    // rx_prev turns the IDLE start condition into a falling edge, so a line stuck low never retriggers
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic p, p_next, pe_next;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p            <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            dout         <= dout_next;
            frame_err    <= fe_next;
            rx_done_tick <= done_next;
`ifdef UART_RX_PARITY_EN
            p            <= p_next;
            parity_err   <= pe_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        dout_next  = dout;
        fe_next    = frame_err;
        done_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_next     = p;
        pe_next    = parity_err;
`endif
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBITS-1:1]};
                        if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        p_next     = rx_s;
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        dout_next  = b;
                        fe_next    = ~rx_s;
                        done_next  = 1'b1;
                        state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        pe_next    = (^b) ^ p;
`endif
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
